condicionador_botoes: RTL and testbench
=======================================

CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4: number of consecutive equal synchronized samples (clock cycles) that qualify a new button vector as stable; legal range 2..255.
REQ-002 SHALL have port clock  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port botoes  input  4  raw, asynchronous, bouncing player buttons, bit i = button i.
REQ-005 SHALL have port limpa  input  1  synchronous clear of jogada, driven by the game controller.
REQ-006 SHALL have port botoes_limpos  output  4  debounced, stable button vector (level).
REQ-007 SHALL have port jogada  output  4  one-hot code of the last valid press, held until next valid press or limpa.
REQ-008 SHALL have port tem_jogada  output  1  one-cycle pulse per valid press; feeds the game datapath.
REQ-009 SHALL have port erro_multiplo  output  1  one-cycle pulse when a stable multi-button vector is accepted.
REQ-010 SHALL have port db_estado  output  2  FSM state code for debug: LIVRE=00, PRESSIONADO=01, INVALIDO=10.

Function
REQ-011 SHALL pass botoes through a 2-flop synchronizer per bit before any other logic.
REQ-012 SHALL run a debounce counter of width ceil(log2(DEBOUNCE+1)) that clears whenever the synchronized vector differs from its previous-cycle value and otherwise increments, saturating at DEBOUNCE.
REQ-013 SHALL load botoes_limpos with the synchronized vector on the edge where the counter reaches DEBOUNCE; a vector changing again before that edge SHALL NOT alter botoes_limpos.
REQ-014 SHALL treat a stable vector as valid one-hot when exactly one bit is 1, zero when all bits are 0, and multi otherwise.
REQ-015 SHALL implement FSM LIVRE -> PRESSIONADO when botoes_limpos becomes one-hot: latch jogada <= botoes_limpos, pulse tem_jogada.
REQ-016 SHALL implement LIVRE -> INVALIDO when botoes_limpos becomes multi: pulse erro_multiplo, jogada unchanged.
REQ-017 SHALL implement PRESSIONADO -> LIVRE on zero; PRESSIONADO -> INVALIDO on multi, pulsing erro_multiplo; PRESSIONADO staying put on a different one-hot value, with no pulse and jogada unchanged.
REQ-018 SHALL implement INVALIDO -> LIVRE only on zero, with no pulse; a one-hot value in INVALIDO SHALL NOT generate tem_jogada.
REQ-019 SHALL produce end-to-end latency, for a clean press held constant: tem_jogada high in the cycle following the (DEBOUNCE+3)-th rising edge after the first edge at which botoes shows the new value (7 edges at default).
REQ-020 SHALL keep tem_jogada and erro_multiplo exactly one cycle wide and never simultaneously high.
REQ-021 SHALL clear jogada to 0000 on the next edge when limpa=1; when limpa coincides with a valid-press edge, the new press SHALL win (jogada loads, tem_jogada pulses).
REQ-022 SHALL generate at most one tem_jogada per press-release cycle regardless of hold duration.

Reset
REQ-023 SHALL, while reset=0, asynchronously force synchronizer flops, counter, botoes_limpos, jogada to 0, tem_jogada and erro_multiplo to 0, FSM to LIVRE (db_estado=00).
REQ-024 SHALL restart qualification after reset deassertion; a button held through reset SHALL produce tem_jogada DEBOUNCE+3 edges after release of reset.
REQ-025 SHALL, on reset asserted mid-press, emit no pulse during reset and no spurious pulse on exit unless the button is still held.

Verification
REQ-026 SHALL show: reset pulse, botoes=0000 for 10 cycles -> all outputs 0, db_estado=00.
REQ-027 SHALL show: botoes=0010 for 10 cycles then 0000 -> single tem_jogada at edge 7, jogada=0010 held after release, db_estado 01 then 00.
REQ-028 SHALL show: botoes toggling 0001/0000 every 2 cycles for 12 cycles (DEBOUNCE=4) -> no tem_jogada, botoes_limpos stays 0000.
REQ-029 SHALL show: botoes=0101 for 10 cycles -> one erro_multiplo, no tem_jogada, db_estado=10; then 0100 for 10 cycles -> still no tem_jogada until 0000 is stable.
REQ-030 SHALL show: jogada=1000 latched, limpa=1 for 1 cycle -> jogada=0000 next edge; limpa coinciding with a valid 0001 press -> jogada=0001, tem_jogada=1.
REQ-031 SHALL show: 0001 held, reset=0 for 2 cycles mid-hold, held after -> outputs 0 during reset, one tem_jogada 7 edges after reset release.

Source files
------------

// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Conditions four raw player buttons for the game datapath. The raw vector
// is synchronized, debounced as a whole vector, and classified as zero,
// one-hot or multi. A small FSM turns stable one-hot presses into a single
// tem_jogada pulse and a latched one-hot jogada code. Stable multi-button
// vectors produce one erro_multiplo pulse.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous reset, active low
//   botoes[3:0]    raw bouncing buttons, bit i = button i
//   limpa          synchronous clear of jogada (a press on the same edge wins)
//   botoes_limpos  debounced stable button vector
//   jogada         one-hot code of the last valid press
//   tem_jogada     one-cycle pulse per valid press
//   erro_multiplo  one-cycle pulse when a stable multi vector is accepted
//   db_estado      FSM state code: LIVRE=00, PRESSIONADO=01, INVALIDO=10
//
// Latency for a clean press: 2 synchronizer edges, 1 edge to register the
// previous-cycle copy, then DEBOUNCE edges of counting. tem_jogada is
// registered on that last edge, so it is high after edge DEBOUNCE+3.
// -----------------------------------------------------------------------------
module condicionador_botoes #(
   parameter int DEBOUNCE = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       limpa,
   output logic [3:0] botoes_limpos,
   output logic [3:0] jogada,
   output logic       tem_jogada,
   output logic       erro_multiplo,
   output logic [1:0] db_estado
);

   // state       | meaning
   // LIVRE       | no button held, waiting for a stable press
   // PRESSIONADO | a valid one-hot press was accepted, waiting for release
   // INVALIDO    | a multi-button vector was seen, waiting for all released
   typedef enum logic [1:0] {
      LIVRE       = 2'b00,
      PRESSIONADO = 2'b01,
      INVALIDO    = 2'b10
   } estado_t;

   localparam int             CW    = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]  C_MAX = CW'(DEBOUNCE);
   localparam logic [CW-1:0]  C_PRE = CW'(DEBOUNCE - 1);

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    r_sync_ant;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_limpos;
   logic [3:0]    r_jogada;
   logic          r_tem_jogada;
   logic          r_erro;
   estado_t       r_estado;

   logic          w_igual;
   logic          w_carga;
   logic          w_novo;
   logic          w_zero;
   logic          w_um;
   logic          w_multi;
   estado_t       w_prox;
   logic [3:0]    w_prox_jogada;
   logic          w_tem_jogada;
   logic          w_erro;

   // Two-flop synchronizer plus a previous-cycle copy for change detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1    <= 4'b0000;
         r_sync2    <= 4'b0000;
         r_sync_ant <= 4'b0000;
      end else begin
         r_sync1    <= botoes;
         r_sync2    <= r_sync1;
         r_sync_ant <= r_sync2;
      end
   end

   assign w_igual = (r_sync2 == r_sync_ant);

   // Load happens on the single edge where the counter steps to DEBOUNCE;
   // after that the counter sits saturated until the vector moves again.
   assign w_carga = w_igual && (r_cnt == C_PRE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (!w_igual) begin
         r_cnt <= '0;
      end else if (r_cnt != C_MAX) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_limpos <= 4'b0000;
      end else if (w_carga) begin
         r_limpos <= r_sync2;
      end
   end

   // The FSM reacts to the vector being loaded, not to botoes_limpos after
   // the load, so the pulse lines up with the load edge. Re-qualifying the
   // same vector after a short glitch is not a new event.
   assign w_novo  = w_carga && (r_sync2 != r_limpos);
   assign w_zero  = (r_sync2 == 4'b0000);
   assign w_um    = !w_zero && ((r_sync2 & (r_sync2 - 4'd1)) == 4'b0000);
   assign w_multi = !w_zero && !w_um;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado     <= LIVRE;
         r_jogada     <= 4'b0000;
         r_tem_jogada <= 1'b0;
         r_erro       <= 1'b0;
      end else begin
         r_estado     <= w_prox;
         r_jogada     <= w_prox_jogada;
         r_tem_jogada <= w_tem_jogada;
         r_erro       <= w_erro;
      end
   end

   // limpa is the default action on jogada; a press overrides it below.
   always_comb begin
      w_prox        = r_estado;
      w_prox_jogada = limpa ? 4'b0000 : r_jogada;
      w_tem_jogada  = 1'b0;
      w_erro        = 1'b0;
      case (r_estado)
         LIVRE: begin
            if (w_novo && w_um) begin
               w_prox        = PRESSIONADO;
               w_prox_jogada = r_sync2;
               w_tem_jogada  = 1'b1;
            end else if (w_novo && w_multi) begin
               w_prox = INVALIDO;
               w_erro = 1'b1;
            end
         end
         PRESSIONADO: begin
            if (w_novo && w_zero) begin
               w_prox = LIVRE;
            end else if (w_novo && w_multi) begin
               w_prox = INVALIDO;
               w_erro = 1'b1;
            end
         end
         INVALIDO: begin
            if (w_novo && w_zero) begin
               w_prox = LIVRE;
            end
         end
         default: begin
            w_prox = LIVRE;
         end
      endcase
   end

   assign botoes_limpos = r_limpos;
   assign jogada        = r_jogada;
   assign tem_jogada    = r_tem_jogada;
   assign erro_multiplo = r_erro;
   assign db_estado     = r_estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// -----------------------------------------------------------------------------
// Bench for condicionador_botoes. A reference model turns raw button samples
// into expected pulses (pushed to a queue) and expected levels; a monitor on
// the falling edge pops and compares. Directed scenarios run first, then a
// randomized mix of clean, bouncing, multi-button, limpa and reset stimulus.
// -----------------------------------------------------------------------------
module tb_condicionador_botoes;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] botoes = 4'b0000;
   logic       limpa = 1'b0;
   logic [3:0] botoes_limpos;
   logic [3:0] jogada;
   logic       tem_jogada;
   logic       erro_multiplo;
   logic [1:0] db_estado;

   condicionador_botoes #(.DEBOUNCE(D)) dut (
      .clock         (clock),
      .reset         (reset),
      .botoes        (botoes),
      .limpa         (limpa),
      .botoes_limpos (botoes_limpos),
      .jogada        (jogada),
      .tem_jogada    (tem_jogada),
      .erro_multiplo (erro_multiplo),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         ciclo;
      bit         kind;     // 0 = tem_jogada, 1 = erro_multiplo
      logic [3:0] vec;
   } ev_t;

   ev_t        sb[$];
   int         m_edge = 0;
   logic [3:0] m_sync1, m_last, m_stable, m_jog, m_newy, m_lvec;
   int         m_rl;
   bit         m_blocked, m_holding, m_load, m_press;
   int         m_ones;

   // A vector is accepted once the synchronized stream has shown it on
   // D+1 consecutive samples. Then the press/error rules apply: a press is
   // only from idle, an error only if not already blocked, and the block
   // lifts only when all buttons are released.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_sync1 = 4'b0; m_last = 4'b0; m_rl = 1;
         m_stable = 4'b0; m_jog = 4'b0;
         m_blocked = 0; m_holding = 0;
         sb.delete();
      end else begin
         m_edge++;
         m_load  = (m_rl == D + 1);
         m_lvec  = m_last;
         m_press = 0;
         m_newy  = m_sync1;
         m_sync1 = botoes;
         if (m_newy == m_last) begin
            if (m_rl < 1000) m_rl++;
         end else begin
            m_rl = 1;
         end
         m_last = m_newy;
         if (m_load && m_lvec != m_stable) begin
            m_ones = $countones(m_lvec);
            if (m_ones == 0) begin
               m_blocked = 0; m_holding = 0;
            end else if (m_ones > 1) begin
               if (!m_blocked) sb.push_back('{m_edge, 1'b1, m_lvec});
               m_blocked = 1; m_holding = 0;
            end else if (!m_blocked && !m_holding) begin
               m_press = 1; m_holding = 1; m_jog = m_lvec;
               sb.push_back('{m_edge, 1'b0, m_lvec});
            end
            m_stable = m_lvec;
         end
         if (limpa && !m_press) m_jog = 4'b0;
      end
   end

   // ---------------- monitor ----------------
   ev_t        mon_e;
   logic       exp_tem, exp_err;
   logic [1:0] m_db;

   always @(negedge clock) begin
      if (!reset) begin
         chk("rst_tem_jogada", 8'(tem_jogada), 8'h0);
         chk("rst_erro_multiplo", 8'(erro_multiplo), 8'h0);
         chk("rst_jogada", 8'(jogada), 8'h0);
         chk("rst_botoes_limpos", 8'(botoes_limpos), 8'h0);
         chk("rst_db_estado", 8'(db_estado), 8'h0);
      end else begin
         exp_tem = 1'b0;
         exp_err = 1'b0;
         if ((tem_jogada || erro_multiplo || (sb.size() > 0 && sb[0].ciclo == m_edge))
             && sb.size() > 0 && sb[0].ciclo == m_edge) begin
            mon_e   = sb.pop_front();
            exp_tem = (mon_e.kind == 1'b0);
            exp_err = (mon_e.kind == 1'b1);
         end
         m_db = m_blocked ? 2'b10 : (m_holding ? 2'b01 : 2'b00);
         chk("tem_jogada", 8'(tem_jogada), 8'(exp_tem));
         chk("erro_multiplo", 8'(erro_multiplo), 8'(exp_err));
         chk("botoes_limpos", 8'(botoes_limpos), 8'(m_stable));
         chk("jogada", 8'(jogada), 8'(m_jog));
         chk("db_estado", 8'(db_estado), 8'(m_db));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #3;
      end
   endtask

   // Drive v and count edges until tem_jogada is seen (bounded).
   task automatic press_latency(input logic [3:0] v, input string nm);
      int lat;
      lat = -1;
      botoes = v;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clock);
         #3;
         if (tem_jogada === 1'b1) begin
            lat = k;
            break;
         end
      end
      chk(nm, 8'(lat), 8'(D + 3));
   endtask

   logic [3:0] vec;

   initial begin
      #2 reset = 1'b0;
      tick(2);
      reset = 1'b1;

      // idle after reset
      tick(10);
      chk("idle_tem", 8'(tem_jogada), 8'h0);
      chk("idle_err", 8'(erro_multiplo), 8'h0);
      chk("idle_limpos", 8'(botoes_limpos), 8'h0);
      chk("idle_jogada", 8'(jogada), 8'h0);
      chk("idle_db", 8'(db_estado), 8'h0);

      // clean press 0010 and release
      press_latency(4'b0010, "lat_0010");
      tick(3);
      chk("hold_jogada", 8'(jogada), 8'h2);
      chk("hold_db", 8'(db_estado), 8'h1);
      botoes = 4'b0000;
      tick(10);
      chk("rel_jogada", 8'(jogada), 8'h2);
      chk("rel_db", 8'(db_estado), 8'h0);

      // bouncing 0001/0000 every 2 cycles never qualifies
      for (int i = 0; i < 3; i++) begin
         botoes = 4'b0001;
         tick(2);
         chk("bounce_limpos", 8'(botoes_limpos), 8'h0);
         botoes = 4'b0000;
         tick(2);
         chk("bounce_limpos", 8'(botoes_limpos), 8'h0);
      end
      tick(10);

      // multi press, then one-hot while invalid, then release
      botoes = 4'b0101;
      tick(10);
      chk("multi_db", 8'(db_estado), 8'h2);
      chk("multi_jogada", 8'(jogada), 8'h2);
      botoes = 4'b0100;
      tick(10);
      chk("inv_onehot_db", 8'(db_estado), 8'h2);
      chk("inv_onehot_jogada", 8'(jogada), 8'h2);
      botoes = 4'b0000;
      tick(10);
      chk("inv_release_db", 8'(db_estado), 8'h0);

      // limpa clears jogada
      press_latency(4'b1000, "lat_1000");
      botoes = 4'b0000;
      tick(10);
      chk("pre_limpa_jogada", 8'(jogada), 8'h8);
      limpa = 1'b1;
      tick(1);
      limpa = 1'b0;
      chk("limpa_jogada", 8'(jogada), 8'h0);

      // limpa on the same edge as a press: press wins
      press_latency(4'b1000, "lat_1000_b");
      botoes = 4'b0000;
      tick(10);
      botoes = 4'b0001;
      tick(D + 2);
      limpa = 1'b1;
      tick(1);
      limpa = 1'b0;
      chk("limpa_press_tem", 8'(tem_jogada), 8'h1);
      chk("limpa_press_jogada", 8'(jogada), 8'h1);
      tick(3);
      botoes = 4'b0000;
      tick(10);

      // reset mid-hold, button still held afterwards
      botoes = 4'b0001;
      tick(10);
      reset = 1'b0;
      #1;
      chk("midrst_jogada", 8'(jogada), 8'h0);
      chk("midrst_db", 8'(db_estado), 8'h0);
      tick(2);
      chk("midrst_tem", 8'(tem_jogada), 8'h0);
      reset = 1'b1;
      press_latency(4'b0001, "lat_after_reset");
      botoes = 4'b0000;
      tick(10);

      // randomized mix
      for (int s = 0; s < 400; s++) begin
         if ($urandom_range(0, 99) < 2) begin
            reset = 1'b0;
            tick($urandom_range(1, 3));
            reset = 1'b1;
         end
         case ($urandom_range(0, 9))
            0, 1, 2, 3: vec = 4'b0000;
            4, 5, 6, 7: vec = 4'b0001 << $urandom_range(0, 3);
            default: begin
               vec = 4'($urandom_range(0, 15));
               while ($countones(vec) < 2) vec = 4'($urandom_range(0, 15));
            end
         endcase
         botoes = vec;
         limpa  = ($urandom_range(0, 7) == 0);
         tick(1);
         limpa = 1'b0;
         tick($urandom_range(0, 11));
      end

      botoes = 4'b0000;
      tick(20);
      chk("scoreboard_drained", 8'(sb.size()), 8'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
